exp_req_scheduler: RTL and testbench
====================================

EXP_REQ_SCHEDULER -- requirements
Module: exp_req_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (fixed at 4 for this revision).
REQ-002 SHALL have parameter OP_W, default 4, width of each X and A operand.
REQ-003 SHALL have parameter P_W, default 15, result width.
REQ-004 SHALL have port i_clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_req  input  4  per-requester request level; bit n = requester n.
REQ-007 SHALL have port i_x  input  16  packed bases; requester n at bits [4n+3:4n].
REQ-008 SHALL have port i_a  input  16  packed exponents; requester n at bits [4n+3:4n].
REQ-009 SHALL have port o_gnt  output  4  one-hot grant pulse; operands are captured on the same edge.
REQ-010 SHALL have port o_busy  output  1  high in CALC and DONE.
REQ-011 SHALL have port o_valid  output  1  one-cycle result strobe.
REQ-012 SHALL have port o_id  output  2  index of the requester that owns o_p.
REQ-013 SHALL have port o_p  output  15  result X^A, saturated.
REQ-014 SHALL have port o_ovf  output  1  saturation flag for the current o_p.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and DONE.
REQ-016 IDLE, any i_req bit high at an edge: SHALL pick a winner by round-robin, starting the search at last-granted+1 (mod 4).
REQ-017 On that edge SHALL latch the winner's X, A and id, set P=1, cnt=0, ovf=0, drive o_gnt one-hot for exactly one cycle, and enter CALC.
REQ-018 IDLE with i_req==0 SHALL remain in IDLE with o_gnt=0.
REQ-019 CALC with cnt<A: each edge SHALL compute P=P*X using a 19-bit product and set cnt=cnt+1.
REQ-020 Product >32767 SHALL set P=0x7FFF and the sticky ovf=1; once ovf=1, P SHALL stay 0x7FFF.
REQ-021 CALC with cnt==A: SHALL load o_p=P, o_ovf=ovf, o_id=id, set o_valid=1 and enter DONE.
REQ-022 DONE SHALL last exactly one cycle, then clear o_valid and return to IDLE.
REQ-023 Latency: grant edge k gives o_valid high in the cycle after edge k+A+1; A=0 gives o_p=1 at edge k+1.
REQ-024 o_p, o_ovf and o_id SHALL hold their values until the next DONE load.
REQ-025 No grant SHALL be issued while o_busy=1; requests arriving then SHALL wait (level-held) and no request SHALL be lost.
REQ-026 A request dropped before it is granted SHALL be ignored.
REQ-027 A granted requester that keeps i_req high SHALL be treated as a new request, subject to round-robin.
REQ-028 With all four requesters continuously requesting, SHALL grant in the order 0,1,2,3,0,...
REQ-029 X=0 with A>0 SHALL give o_p=0; X=0 with A=0 SHALL give o_p=1.
REQ-030 Operand changes on i_x/i_a after the grant edge SHALL NOT affect the running job.

Reset
REQ-031 i_rst_n low SHALL immediately force state=IDLE, o_gnt=0, o_busy=0, o_valid=0, o_id=0, o_p=0, o_ovf=0, internal P=1, cnt=0.
REQ-032 Reset SHALL set the last-granted pointer to 3, so requester 0 wins the first arbitration.
REQ-033 Reset mid-CALC SHALL abort the job with no o_valid; after release, pending requests SHALL be re-arbitrated from requester 0.

Verification
REQ-034 Bench SHALL cover: i_req=0010, X1=3, A1=4 -> o_gnt=0010 one cycle; o_valid 5 edges later; o_p=81, o_id=1, o_ovf=0.
REQ-035 Bench SHALL cover: i_req=1111 held, all X=2, A=3 -> grants 0001,0010,0100,1000,0001; every result o_p=8 with o_id 0,1,2,3.
REQ-036 Bench SHALL cover: X=2, A=15 -> o_p=0x7FFF, o_ovf=1; a following job X=2, A=14 -> o_p=16384, o_ovf=0.
REQ-037 Bench SHALL cover: A=0, X=9 -> o_p=1 one edge after grant; A=3, X=0 -> o_p=0.
REQ-038 Bench SHALL cover: i_rst_n low during CALC (X=5, A=6) -> no o_valid, all outputs 0; after release with i_req=1001 -> first grant 0001.
REQ-039 Bench SHALL cover: i_req pulse on requester 2 during CALC, dropped before DONE -> never granted.

Source files
------------

// File: rtl/exp_req_scheduler.sv
// Round-robin scheduler that grants one of N_REQ requesters and computes its
// saturated X^A by iterated multiplication, one multiply per clock.
module exp_req_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned OP_W  = 4,
    parameter int unsigned P_W   = 15
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*OP_W-1:0]     i_x,
    input  logic [N_REQ*OP_W-1:0]     i_a,
    output logic [N_REQ-1:0]          o_gnt,
    output logic                      o_busy,
    output logic                      o_valid,
    output logic [$clog2(N_REQ)-1:0]  o_id,
    output logic [P_W-1:0]            o_p,
    output logic                      o_ovf
);

    localparam int unsigned ID_W   = $clog2(N_REQ);
    localparam int unsigned PROD_W = P_W + OP_W;
    localparam logic [P_W-1:0] P_MAX = {P_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_nx;
    logic [ID_W-1:0]   r_last,  w_last_nx;
    logic [OP_W-1:0]   r_x,     w_x_nx;
    logic [OP_W-1:0]   r_a,     w_a_nx;
    logic [ID_W-1:0]   r_id,    w_id_nx;
    logic [P_W-1:0]    r_p,     w_p_nx;
    logic [OP_W-1:0]   r_cnt,   w_cnt_nx;
    logic              r_ovf,   w_ovf_nx;
    logic [N_REQ-1:0]  r_gnt,   w_gnt_nx;
    logic              r_busy,  w_busy_nx;
    logic              r_valid, w_valid_nx;
    logic [P_W-1:0]    r_op,    w_op_nx;
    logic [ID_W-1:0]   r_oid,   w_oid_nx;
    logic              r_oovf,  w_oovf_nx;

    logic              w_found;
    logic [ID_W-1:0]   w_win;
    logic [ID_W-1:0]   w_idx;
    logic [OP_W-1:0]   w_sel_x;
    logic [OP_W-1:0]   w_sel_a;
    logic [PROD_W-1:0] w_prod;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            w_idx = r_last + ID_W'(i);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        w_sel_x = '0;
        w_sel_a = '0;
        for (int n = 0; n < int'(N_REQ); n++) begin
            if (w_win == ID_W'(n)) begin
                w_sel_x = i_x[n*OP_W +: OP_W];
                w_sel_a = i_a[n*OP_W +: OP_W];
            end
        end
    end

    assign w_prod = PROD_W'(r_p) * PROD_W'(r_x);

    // Next-state and datapath update
    always_comb begin
        w_state_nx = r_state;
        w_last_nx  = r_last;
        w_x_nx     = r_x;
        w_a_nx     = r_a;
        w_id_nx    = r_id;
        w_p_nx     = r_p;
        w_cnt_nx   = r_cnt;
        w_ovf_nx   = r_ovf;
        w_gnt_nx   = '0;
        w_busy_nx  = r_busy;
        w_valid_nx = 1'b0;
        w_op_nx    = r_op;
        w_oid_nx   = r_oid;
        w_oovf_nx  = r_oovf;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nx = CALC;
                    w_last_nx  = w_win;
                    w_x_nx     = w_sel_x;
                    w_a_nx     = w_sel_a;
                    w_id_nx    = w_win;
                    w_p_nx     = P_W'(1);
                    w_cnt_nx   = '0;
                    w_ovf_nx   = 1'b0;
                    w_gnt_nx   = N_REQ'(1) << w_win;
                    w_busy_nx  = 1'b1;
                end
            end
            CALC: begin
                if (r_cnt == r_a) begin
                    w_op_nx    = r_p;
                    w_oid_nx   = r_id;
                    w_oovf_nx  = r_ovf;
                    w_valid_nx = 1'b1;
                    w_state_nx = DONE;
                end else begin
                    w_cnt_nx = r_cnt + OP_W'(1);
                    // Saturation is sticky: later multiplies cannot leave the ceiling
                    if (r_ovf || (w_prod > PROD_W'(P_MAX))) begin
                        w_p_nx   = P_MAX;
                        w_ovf_nx = 1'b1;
                    end else begin
                        w_p_nx = w_prod[P_W-1:0];
                    end
                end
            end
            DONE: begin
                w_state_nx = IDLE;
                w_busy_nx  = 1'b0;
            end
            default: begin
                w_state_nx = IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    // State register; pointer resets to the top so requester 0 wins first
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_last  <= ID_W'(N_REQ - 1);
            r_x     <= '0;
            r_a     <= '0;
            r_id    <= '0;
            r_p     <= P_W'(1);
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_op    <= '0;
            r_oid   <= '0;
            r_oovf  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_last  <= w_last_nx;
            r_x     <= w_x_nx;
            r_a     <= w_a_nx;
            r_id    <= w_id_nx;
            r_p     <= w_p_nx;
            r_cnt   <= w_cnt_nx;
            r_ovf   <= w_ovf_nx;
            r_gnt   <= w_gnt_nx;
            r_busy  <= w_busy_nx;
            r_valid <= w_valid_nx;
            r_op    <= w_op_nx;
            r_oid   <= w_oid_nx;
            r_oovf  <= w_oovf_nx;
        end
    end

    assign o_gnt   = r_gnt;
    assign o_busy  = r_busy;
    assign o_valid = r_valid;
    assign o_id    = r_oid;
    assign o_p     = r_op;
    assign o_ovf   = r_oovf;

endmodule

// File: tb/tb_exp_req_scheduler.sv
// Bench for exp_req_scheduler: directed scenarios plus random traffic, all
// outputs compared every cycle against a job-level reference model.
module tb_exp_req_scheduler;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [3:0]  i_req = '0;
    logic [15:0] i_x = '0;
    logic [15:0] i_a = '0;
    logic [3:0]  o_gnt;
    logic        o_busy;
    logic        o_valid;
    logic [1:0]  o_id;
    logic [14:0] o_p;
    logic        o_ovf;

    int n_checks = 0;
    int n_errors = 0;

    exp_req_scheduler #(.N_REQ(4), .OP_W(4), .P_W(15)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_req),
        .i_x     (i_x),
        .i_a     (i_a),
        .o_gnt   (o_gnt),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .o_id    (o_id),
        .o_p     (o_p),
        .o_ovf   (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // X^A with sticky saturation at 32767; returns {ovf, p}
    function automatic logic [15:0] sat_pow(input int x, input int a);
        int p = 1;
        bit ovf = 0;
        for (int i = 0; i < a; i++) begin
            if (!ovf) begin
                p = p * x;
                if (p > 32767) begin
                    p = 32767;
                    ovf = 1;
                end
            end
        end
        return {ovf, 15'(p)};
    endfunction

    // Reference model: a job occupies A+2 edges; result appears A+1 edges after grant
    int          m_cd, m_vd, m_last, m_c;
    bit          m_found;
    logic [14:0] j_p;
    logic        j_ovf;
    logic [1:0]  j_id;
    logic [15:0] m_res;
    logic [3:0]  e_gnt;
    logic        e_valid, e_busy, e_ovf;
    logic [1:0]  e_id;
    logic [14:0] e_p;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_cd = 0; m_vd = -1; m_last = 3;
            e_gnt = '0; e_valid = 0; e_busy = 0; e_ovf = 0; e_id = '0; e_p = '0;
        end else begin
            e_gnt = '0;
            e_valid = 0;
            if (m_cd == 0) begin
                m_found = 0;
                for (int i = 1; i <= 4; i++) begin
                    m_c = (m_last + i) % 4;
                    if (!m_found && i_req[m_c]) begin
                        m_found = 1;
                        m_last = m_c;
                    end
                end
                if (m_found) begin
                    m_res = sat_pow(int'(i_x[m_last*4 +: 4]), int'(i_a[m_last*4 +: 4]));
                    j_p = m_res[14:0];
                    j_ovf = m_res[15];
                    j_id = 2'(m_last);
                    m_cd = int'(i_a[m_last*4 +: 4]) + 2;
                    m_vd = m_cd - 1;
                    e_gnt = 4'(1 << m_last);
                end
            end else begin
                m_cd--;
                m_vd--;
                if (m_vd == 0) begin
                    e_valid = 1;
                    e_p = j_p;
                    e_id = j_id;
                    e_ovf = j_ovf;
                end
            end
            e_busy = (m_cd != 0);
        end
    end

    always @(negedge i_clk) begin
        chk("gnt",   32'(o_gnt),   32'(e_gnt));
        chk("valid", 32'(o_valid), 32'(e_valid));
        chk("busy",  32'(o_busy),  32'(e_busy));
        chk("p",     32'(o_p),     32'(e_p));
        chk("id",    32'(o_id),    32'(e_id));
        chk("ovf",   32'(o_ovf),   32'(e_ovf));
    end

    task automatic wait_gnt(output logic [3:0] g, output int n);
        n = 0;
        while (o_gnt == 4'b0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (o_gnt == 4'b0) chk("gnt_timeout", 32'(1), 32'(0));
        g = o_gnt;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_valid) chk("valid_timeout", 32'(1), 32'(0));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        #1 i_rst_n = 1'b0;
        #1;
        chk("rst_gnt",   32'(o_gnt),   32'(0));
        chk("rst_valid", 32'(o_valid), 32'(0));
        chk("rst_busy",  32'(o_busy),  32'(0));
        chk("rst_p",     32'(o_p),     32'(0));
        chk("rst_id",    32'(o_id),    32'(0));
        chk("rst_ovf",   32'(o_ovf),   32'(0));
        repeat (2) @(negedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    task automatic one_job(input int r, input int x, input int a, input int exp_p,
                           input int exp_ovf, input int exp_lat, input string tag);
        logic [3:0] g;
        int n;
        @(negedge i_clk);
        i_req = 4'(1 << r);
        i_x[r*4 +: 4] = 4'(x);
        i_a[r*4 +: 4] = 4'(a);
        wait_gnt(g, n);
        chk({tag, "_gnt"}, 32'(g), 32'(1 << r));
        i_req = '0;
        i_x = 16'(~i_x);
        i_a = 16'(~i_a);
        wait_valid(n);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_p"},   32'(o_p),   32'(exp_p));
        chk({tag, "_id"},  32'(o_id),  32'(r));
        chk({tag, "_ovf"}, 32'(o_ovf), 32'(exp_ovf));
        wait_idle();
    endtask

    initial begin
        logic [3:0] g;
        int n;
        logic [3:0] seen;
        repeat (2) @(negedge i_clk);
        #1 i_rst_n = 1'b1;
        @(negedge i_clk);

        one_job(1, 3, 4, 81, 0, 5, "pow3_4");
        one_job(0, 2, 15, 32767, 1, 16, "sat");
        one_job(0, 2, 14, 16384, 0, 15, "pow2_14");
        one_job(2, 9, 0, 1, 0, 1, "a0");
        one_job(3, 0, 3, 0, 0, 4, "x0");

        // All four requesting: strict rotation starting after the last grant (3)
        @(negedge i_clk);
        i_req = 4'b1111;
        i_x = 16'h2222;
        i_a = 16'h3333;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, n);
            chk("rr_gnt", 32'(g), 32'(1 << (k % 4)));
            if (k == 4) i_req = '0;
            if (k < 4) begin
                wait_valid(n);
                chk("rr_p",  32'(o_p),  32'(8));
                chk("rr_id", 32'(o_id), 32'(k));
                @(negedge i_clk);
            end
        end
        wait_idle();

        // Reset mid-calculation aborts the job; arbitration restarts at 0
        @(negedge i_clk);
        i_req = 4'b0001;
        i_x = 16'h0005;
        i_a = 16'h0006;
        wait_gnt(g, n);
        i_req = 4'b1001;
        repeat (2) @(negedge i_clk);
        do_reset();
        @(negedge i_clk);
        chk("post_rst_gnt", 32'(o_gnt), 32'b0001);
        i_req = '0;
        wait_idle();

        // Requester 2 pulses while busy and drops before the job ends
        @(negedge i_clk);
        i_req = 4'b0001;
        i_x = 16'h0001;
        i_a = 16'h0006;
        wait_gnt(g, n);
        i_req = 4'b0100;
        repeat (2) @(negedge i_clk);
        i_req = '0;
        seen = '0;
        repeat (12) begin
            @(negedge i_clk);
            seen |= o_gnt;
        end
        chk("dropped_req", 32'(seen), 32'(0));

        // Random traffic, operands churning every cycle
        for (int c = 0; c < 4000; c++) begin
            @(negedge i_clk);
            if ($urandom_range(0, 3) == 0) i_req = 4'($urandom_range(0, 15));
            i_x = 16'($urandom);
            i_a = 16'($urandom);
            if ($urandom_range(0, 599) == 0) do_reset();
        end
        i_req = '0;
        repeat (20) @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
